mem_access_unit: RTL and testbench

- Sits between the multi-cycle control FSM and the unified instruction/data memory.
- Turns the FSM's mem_read/mem_write/IorD/ir_write level requests into a req/ack memory transaction.
- Captures read data into the instruction register (IR) or the memory data register (MDR).
- Raises stall so the FSM holds its current state until the access completes.

---
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit: turns control-FSM level requests into a req/ack memory transaction and captures IR/MDR.
// Optional macro MISALIGN_CHECK_EN rejects word-misaligned accesses without issuing mem_req.
module mem_access_unit #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_read,
   input  logic            req_write,
   input  logic            iord,
   input  logic            ir_write,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] alu_out,
   input  logic [XLEN-1:0] wdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic [XLEN-1:0] ir,
   output logic [XLEN-1:0] mdr,
   output logic            stall,
   output logic            access_done,
   output logic            err,
   output logic            misalign
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic            r_we;
   logic            r_irw;
   logic            r_err;
   logic            w_req;
   logic            w_misal;
   logic            w_timeout;
   logic [XLEN-1:0] w_sel_addr;

   assign w_req      = req_read | req_write;
   assign w_sel_addr = iord ? alu_out : pc;
   // Last permitted WAIT cycle: with no ack here the access is abandoned.
   assign w_timeout  = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign mem_we     = r_we;
   assign err        = r_err;

`ifdef MISALIGN_CHECK_EN
   logic r_mis;
   assign w_misal  = (w_sel_addr[1:0] != 2'b00);
   assign misalign = r_mis & (r_state == S_DONE);
`else
   assign w_misal  = 1'b0;
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      mem_req     = 1'b0;
      stall       = 1'b0;
      access_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               stall  = 1'b1;
               w_next = w_misal ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            mem_req = 1'b1;
            stall   = 1'b1;
            if (mem_ack || w_timeout) w_next = S_DONE;
         end
         S_DONE: begin
            access_done = 1'b1;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         ir        <= '0;
         mdr       <= '0;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_irw     <= 1'b0;
         r_err     <= 1'b0;
`ifdef MISALIGN_CHECK_EN
         r_mis     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  mem_addr  <= w_sel_addr;
                  mem_wdata <= wdata;
                  r_we      <= req_write;
                  r_irw     <= ir_write;
                  r_cnt     <= '0;
                  if ((req_read & req_write) | w_misal) r_err <= 1'b1;
`ifdef MISALIGN_CHECK_EN
                  r_mis     <= w_misal;
`endif
               end
            end
            S_WAIT: begin
               if (mem_ack) begin
                  if (!r_we) begin
                     if (r_irw) ir  <= mem_rdata;
                     else       mdr <= mem_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
                  if (w_timeout) r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized accesses against a transaction-level model.
module tb_mem_access_unit;
   localparam int unsigned XLEN = 32;
   localparam int unsigned TO   = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            req_read = 1'b0, req_write = 1'b0, iord = 1'b0, ir_write = 1'b0;
   logic [XLEN-1:0] pc = '0, alu_out = '0, wdata = '0, mem_rdata = '0;
   logic            mem_ack = 1'b0;
   logic            mem_req, mem_we, stall, access_done, err, misalign;
   logic [XLEN-1:0] mem_addr, mem_wdata, ir, mdr;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   logic [31:0] m_ir  = '0;
   logic [31:0] m_mdr = '0;
   logic        m_err = 1'b0;

   mem_access_unit #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
      .iord(iord), .ir_write(ir_write), .pc(pc), .alu_out(alu_out), .wdata(wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir(ir), .mdr(mdr), .stall(stall),
      .access_done(access_done), .err(err), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Called in an IDLE cycle, #1 after the rising edge; returns likewise in the following IDLE cycle.
   task automatic do_access(input logic rd, input logic wr, input logic io, input logic irw,
                            input logic [31:0] vpc, input logic [31:0] valu, input logic [31:0] vwd,
                            input int ackd, input logic [31:0] rdat);
      logic [31:0] addr;
      logic        mis;
      int          exp_waits;
      int          waits;
      addr = io ? valu : vpc;
      mis  = 1'b0;
`ifdef MISALIGN_CHECK_EN
      mis  = (addr[1:0] != 2'b00);
`endif
      req_read = rd; req_write = wr; iord = io; ir_write = irw;
      pc = vpc; alu_out = valu; wdata = vwd;
      #1;
      check_eq("stall_req", stall, 1);
      check_eq("req_idle", mem_req, 0);
      @(posedge clk); #1;
      req_read = 1'b0; req_write = 1'b0;
      wdata = ~vwd; pc = ~vpc; alu_out = ~valu;
      waits = 0;
      while (mem_req === 1'b1 && waits < 40) begin
         check_eq("addr", mem_addr, addr);
         check_eq("we", mem_we, wr);
         if (wr) check_eq("wdata", mem_wdata, vwd);
         check_eq("stall_wait", stall, 1);
         if (waits == ackd) begin
            mem_ack = 1'b1;
            mem_rdata = rdat;
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
         mem_rdata = $urandom;
         waits++;
      end
      if (mis) begin
         exp_waits = 0;
         m_err = 1'b1;
      end else if (ackd < int'(TO)) begin
         exp_waits = ackd + 1;
         if (!wr) begin
            if (irw) m_ir = rdat;
            else     m_mdr = rdat;
         end
      end else begin
         exp_waits = TO;
         m_err = 1'b1;
      end
      if (rd && wr) m_err = 1'b1;
      check_eq("wait_cycles", waits, exp_waits);
      check_eq("done", access_done, 1);
      check_eq("misalign", misalign, mis);
      check_eq("stall_done", stall, 0);
      check_eq("ir", ir, m_ir);
      check_eq("mdr", mdr, m_mdr);
      check_eq("err", err, m_err);
      @(posedge clk); #1;
      check_eq("done_pulse", access_done, 0);
      check_eq("req_after", mem_req, 0);
   endtask

   task automatic late_ack;
      mem_ack = 1'b1;
      mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check_eq("lateack_req", mem_req, 0);
      check_eq("lateack_done", access_done, 0);
      check_eq("lateack_ir", ir, m_ir);
      check_eq("lateack_mdr", mdr, m_mdr);
      check_eq("lateack_stall", stall, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      #1;
      check_eq("rst_req", mem_req, 0);
      check_eq("rst_stall", stall, 0);
      check_eq("rst_ir", ir, 0);
      check_eq("rst_mdr", mdr, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_addr", mem_addr, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check_eq("idle_done", access_done, 0);

      // fetch, store (ack on third WAIT cycle), back-to-back fetch
      do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'h0, 0, 32'h0000_0093);
      do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h1234_5678);
      do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0014, 32'h0, 32'h0, 1, 32'h0000_0513);
      // load to MDR, then one that never gets acked
      do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0200, 32'h0, 0, 32'hCAFE_F00D);
      do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0204, 32'h0, 99, 32'hBAD0_BAD0);
      late_ack();
      do_access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0300, 32'h5555_AAAA, 0, 32'h0);
      do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0102, 32'h0, 0, 32'h7777_0001);

      // asynchronous reset in the middle of WAIT
      req_read = 1'b1; iord = 1'b0; ir_write = 1'b1; pc = 32'h0000_0040;
      @(posedge clk); #1;
      req_read = 1'b0;
      check_eq("midwait_req", mem_req, 1);
      #2 reset = 1'b0;
      #1;
      check_eq("arst_req", mem_req, 0);
      check_eq("arst_stall", stall, 0);
      check_eq("arst_ir", ir, 0);
      check_eq("arst_mdr", mdr, 0);
      check_eq("arst_err", err, 0);
      m_ir = '0; m_mdr = '0; m_err = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_req", mem_req, 0);
      check_eq("post_rst_done", access_done, 0);

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 9);
         do_access(op < 5 || op == 9, op >= 5, 1'($urandom), 1'($urandom),
                   $urandom, $urandom, $urandom, $urandom_range(0, 5), $urandom);
         if ($urandom_range(0, 3) == 0) late_ack();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
